// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle for sensor_conditioner: raw contacts and temperature samples in,
// conditioned flags and temperature out.
interface sensor_conditioner_if;
  logic       raw_fd;
  logic       raw_rd;
  logic       raw_w;
  logic       raw_fa;
  logic [7:0] raw_temp;
  logic       temp_strobe;
  logic       SFD;
  logic       SRD;
  logic       SW;
  logic       SFA;
  logic [6:0] ST;
  logic       st_valid;

  modport master (
    output raw_fd, raw_rd, raw_w, raw_fa, raw_temp, temp_strobe,
    input  SFD, SRD, SW, SFA, ST, st_valid
  );

  modport slave (
    input  raw_fd, raw_rd, raw_w, raw_fa, raw_temp, temp_strobe,
    output SFD, SRD, SW, SFA, ST, st_valid
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces door/window/fire contacts and saturates temperature samples.
// Define TEMP_AVG_EN to add a 4-sample moving-average filter on the temperature path.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TEMP_MAX        = 127
) (
  input logic                 clk,
  input logic                 Rst,
  sensor_conditioner_if.slave bus_io
);

  localparam logic [3:0] CntMax     = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] TempMaxRaw = 8'(TEMP_MAX);
  localparam logic [6:0] TempMaxSt  = 7'(TEMP_MAX);

  // Bit order for all contact vectors: 0 fd, 1 rd, 2 w, 3 fa.
  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      flag_q, flag_d;
  logic [3:0][3:0] cnt_q, cnt_d;

  assign raw = {bus_io.raw_fa, bus_io.raw_w, bus_io.raw_rd, bus_io.raw_fd};

  always_comb begin
    flag_d = flag_q;
    cnt_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != flag_q[i]) begin
        // Fire alarm asserts immediately; only its release is debounced.
        if (i == 3 && sync2_q[i]) begin
          flag_d[i] = 1'b1;
        end else if (cnt_q[i] + 4'd1 == CntMax) begin
          flag_d[i] = ~flag_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [6:0] sample;
  logic [6:0] st_q, st_d;
  logic       valid_q, valid_d;

  assign sample = (bus_io.raw_temp > TempMaxRaw) ? TempMaxSt : bus_io.raw_temp[6:0];

`ifdef TEMP_AVG_EN
  logic [3:0][6:0] buf_q, buf_d;
  logic [2:0]      fill_q, fill_d;
  logic [8:0]      sum;

  always_comb begin
    buf_d   = buf_q;
    fill_d  = fill_q;
    st_d    = st_q;
    valid_d = valid_q;
    if (bus_io.temp_strobe) begin
      buf_d = {buf_q[2:0], sample};
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
    sum = {2'b00, buf_d[0]} + {2'b00, buf_d[1]} + {2'b00, buf_d[2]} + {2'b00, buf_d[3]};
    // Output stays 0 until the buffer holds four real samples.
    if (bus_io.temp_strobe && fill_d == 3'd4) begin
      st_d    = sum[8:2];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end
`else
  always_comb begin
    st_d    = st_q;
    valid_d = valid_q;
    if (bus_io.temp_strobe) begin
      st_d    = sample;
      valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!Rst) begin
      st_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.SFD      = flag_q[0];
  assign bus_io.SRD      = flag_q[1];
  assign bus_io.SW       = flag_q[2];
  assign bus_io.SFA      = flag_q[3];
  assign bus_io.ST       = st_q;
  assign bus_io.st_valid = valid_q;

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable cycles needed to change a debounced door or window output (range 1..15).
REQ-002 Parameter TEMP_MAX, default 127, saturation ceiling for the temperature output.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset; synchronous and active-low (0 resets on the next rising clk edge).
REQ-005 raw_fd  input  1  asynchronous front-door contact.
REQ-006 raw_rd  input  1  asynchronous rear-door contact.
REQ-007 raw_w  input  1  asynchronous window contact.
REQ-008 raw_fa  input  1  asynchronous fire-alarm detector.
REQ-009 raw_temp  input  8  temperature sample, unsigned, qualified by temp_strobe.
REQ-010 temp_strobe  input  1  one-cycle pulse marking raw_temp valid.
REQ-011 SFD, SRD, SW, SFA  output  1 each  conditioned sensor flags for the home controller.
REQ-012 ST  output  7  conditioned temperature for the home controller.
REQ-013 st_valid  output  1  ST holds a qualified value.

Function
REQ-014 Each raw_* input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Door and window debounce: a per-input counter SHALL increment while the synchronized input differs from its output, and SHALL clear to 0 in any cycle where they match.
REQ-016 A debounced output SHALL toggle, and its counter SHALL clear, in the cycle the counter reaches DEBOUNCE_CYCLES. Latency from a raw edge to the output is 2+DEBOUNCE_CYCLES cycles.
REQ-017 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change SFD, SRD or SW.
REQ-018 SFA fast path: SFA SHALL rise one cycle after synchronized fa rises, with no debounce. SFA SHALL fall only after synchronized fa has been 0 for DEBOUNCE_CYCLES cycles.
REQ-019 Temperature saturation: a sample with raw_temp > TEMP_MAX SHALL be clamped to TEMP_MAX before any further use.
REQ-020 Without TEMP_AVG_EN, on a temp_strobe cycle ST SHALL load the clamped sample at the next edge, and st_valid SHALL go to 1 and stay 1 until reset.
REQ-021 Samples arriving on consecutive strobe cycles SHALL each be accepted; no sample is dropped.
REQ-022 A temp_strobe in a cycle with Rst=0 SHALL be ignored.
REQ-023 ST and st_valid SHALL hold their values between strobes.

Reset
REQ-024 With Rst=0 at a clk edge, all of the following SHALL clear to 0: synchronizers, counters, SFD, SRD, SW, SFA, ST, st_valid and the sample buffer.
REQ-025 Reset mid-debounce SHALL discard partial counts; after release, counting restarts from 0.
REQ-026 A raw input held at 1 through reset release SHALL reach its output 2+DEBOUNCE_CYCLES cycles after release (SFA: 3 cycles).

Configuration
REQ-027 Macro TEMP_AVG_EN, when defined, SHALL compile in a 4-entry sample buffer for moving-average temperature filtering.
REQ-028 With TEMP_AVG_EN, each accepted clamped sample SHALL shift into the buffer. ST SHALL equal the 9-bit sum of the 4 entries shifted right by 2 (truncated), updated the cycle after the strobe.
REQ-029 With TEMP_AVG_EN, st_valid SHALL stay 0 and ST SHALL stay 0 until 4 samples have been accepted since reset. st_valid then stays 1 until reset.
REQ-030 Without TEMP_AVG_EN, no buffer logic SHALL exist and REQ-020 applies.

Verification
REQ-031 Reset, then raw_fd held 1 with DEBOUNCE_CYCLES=4 -> SFD=0 for 5 cycles, SFD=1 on cycle 6.
REQ-032 raw_w pulse of 3 cycles, DEBOUNCE_CYCLES=4 -> SW stays 0 throughout.
REQ-033 raw_fa rises -> SFA=1 within 3 cycles. raw_fa falls -> SFA holds 1 for 4 further cycles after synchronization, then 0.
REQ-034 No macro: strobe raw_temp=200 -> ST=127, st_valid=1 next cycle. Strobe raw_temp=25 -> ST=25.
REQ-035 TEMP_AVG_EN: back-to-back strobes 20, 22, 24, 26 -> st_valid 0 until after the 4th sample, then ST=23. Further strobe 30 -> ST=25.
REQ-036 Rst=0 for one cycle during a debounce count and concurrent with a strobe -> all outputs 0, strobe ignored, st_valid 0.
